// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared register.
// Each transaction is IDLE -> GRANT -> ACK; the owner's data commits on the GRANT exit edge.
module shared_reg_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk1,
  input  logic                  s_reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic [OW-1:0]         owner,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t          state;
  logic [OW-1:0]   last;
  logic [OW-1:0]   win;
  logic [NREQ-1:0] win_oh;
  int              idx;

  // Scan from far to near so the nearest set bit after last wins.
  always_comb begin
    win = '0;
    idx = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) win = OW'(idx);
    end
    win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win;
  end

  always_ff @(posedge clk1) begin
    if (s_reset) begin
      state <= IDLE;
      q     <= '0;
      grant <= '0;
      ack   <= '0;
      owner <= '0;
      busy  <= 1'b0;
      last  <= OW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= win_oh;
            owner <= win;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          grant <= '0;
          // The pointer advances even on a withdrawn request.
          last  <= owner;
          if (req[owner]) begin
            q          <= wdata[int'(owner)*WIDTH +: WIDTH];
            ack[owner] <= 1'b1;
            state      <= ACK;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        ACK: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed vector bench for shared_reg_arbiter (WIDTH=8, NREQ=4).
module tb_shared_reg_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;

  logic                  clk1 = 1'b0;
  logic                  s_reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       grant, ack;
  logic [WIDTH-1:0]      q;
  logic [1:0]            owner;
  logic                  busy;

  shared_reg_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk1(clk1), .s_reset(s_reset), .req(req), .wdata(wdata),
    .grant(grant), .ack(ack), .q(q), .owner(owner), .busy(busy)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [31:0] wd;
    logic [3:0]  g;
    logic [3:0]  a;
    logic [7:0]  qq;
    logic [1:0]  o;
    logic        b;
  } vec_t;

  vec_t v[39];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic vec_t mk(logic rst, logic [3:0] rq, logic [31:0] wd,
                              logic [3:0] g, logic [3:0] a, logic [7:0] qq,
                              logic [1:0] o, logic b);
    vec_t t;
    t.rst = rst; t.rq = rq; t.wd = wd; t.g = g; t.a = a; t.qq = qq; t.o = o; t.b = b;
    return t;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s vec%0d actual=%h expected=%h", nm, idx, act, exp);
  endtask

  initial begin
    int n;
    // Test 1: reset with all requests high, then first grant is requester 0.
    v[0]  = mk(1, 4'hF, 32'h13121110, 4'h0, 4'h0, 8'h00, 0, 0);
    v[1]  = mk(1, 4'hF, 32'h13121110, 4'h0, 4'h0, 8'h00, 0, 0);
    v[2]  = mk(0, 4'hF, 32'h13121110, 4'h1, 4'h0, 8'h00, 0, 1);
    // Test 3: all requesting, round robin 0,1,2,3,0.
    v[3]  = mk(0, 4'hF, 32'h13121110, 4'h0, 4'h1, 8'h10, 0, 1);
    v[4]  = mk(0, 4'hF, 32'h13121110, 4'h0, 4'h0, 8'h10, 0, 0);
    v[5]  = mk(0, 4'hF, 32'h13121110, 4'h2, 4'h0, 8'h10, 1, 1);
    v[6]  = mk(0, 4'hF, 32'h13121110, 4'h0, 4'h2, 8'h11, 1, 1);
    v[7]  = mk(0, 4'hF, 32'h13121110, 4'h0, 4'h0, 8'h11, 1, 0);
    v[8]  = mk(0, 4'hF, 32'h13121110, 4'h4, 4'h0, 8'h11, 2, 1);
    v[9]  = mk(0, 4'hF, 32'h13121110, 4'h0, 4'h4, 8'h12, 2, 1);
    v[10] = mk(0, 4'hF, 32'h13121110, 4'h0, 4'h0, 8'h12, 2, 0);
    v[11] = mk(0, 4'hF, 32'h13121110, 4'h8, 4'h0, 8'h12, 3, 1);
    v[12] = mk(0, 4'hF, 32'h13121110, 4'h0, 4'h8, 8'h13, 3, 1);
    v[13] = mk(0, 4'hF, 32'h13121110, 4'h0, 4'h0, 8'h13, 3, 0);
    v[14] = mk(0, 4'hF, 32'h13121110, 4'h1, 4'h0, 8'h13, 0, 1);
    v[15] = mk(0, 4'hF, 32'h13121110, 4'h0, 4'h1, 8'h10, 0, 1);
    v[16] = mk(0, 4'h0, 32'h13121110, 4'h0, 4'h0, 8'h10, 0, 0);
    // Test 2: single requester 0 writes A5.
    v[17] = mk(0, 4'h1, 32'h131211A5, 4'h1, 4'h0, 8'h10, 0, 1);
    v[18] = mk(0, 4'h1, 32'h131211A5, 4'h0, 4'h1, 8'hA5, 0, 1);
    v[19] = mk(0, 4'h0, 32'h131211A5, 4'h0, 4'h0, 8'hA5, 0, 0);
    // Test 4: requester 1 withdraws during GRANT; pointer still advances.
    v[20] = mk(0, 4'h2, 32'h13121110, 4'h2, 4'h0, 8'hA5, 1, 1);
    v[21] = mk(0, 4'h0, 32'h13121110, 4'h0, 4'h0, 8'hA5, 1, 0);
    v[22] = mk(0, 4'h6, 32'h13121110, 4'h4, 4'h0, 8'hA5, 2, 1);
    v[23] = mk(0, 4'h6, 32'h13121110, 4'h0, 4'h4, 8'h12, 2, 1);
    v[24] = mk(0, 4'h0, 32'h13121110, 4'h0, 4'h0, 8'h12, 2, 0);
    // Test 6: requesters 1 and 2 held, alternating.
    v[25] = mk(0, 4'h6, 32'h13121110, 4'h2, 4'h0, 8'h12, 1, 1);
    v[26] = mk(0, 4'h6, 32'h13121110, 4'h0, 4'h2, 8'h11, 1, 1);
    v[27] = mk(0, 4'h6, 32'h13121110, 4'h0, 4'h0, 8'h11, 1, 0);
    v[28] = mk(0, 4'h6, 32'h13121110, 4'h4, 4'h0, 8'h11, 2, 1);
    v[29] = mk(0, 4'h6, 32'h13121110, 4'h0, 4'h4, 8'h12, 2, 1);
    v[30] = mk(0, 4'h6, 32'h13121110, 4'h0, 4'h0, 8'h12, 2, 0);
    v[31] = mk(0, 4'h6, 32'h13121110, 4'h2, 4'h0, 8'h12, 1, 1);
    v[32] = mk(0, 4'h6, 32'h13121110, 4'h0, 4'h2, 8'h11, 1, 1);
    v[33] = mk(0, 4'h0, 32'h13121110, 4'h0, 4'h0, 8'h11, 1, 0);
    // Test 5: reset during requester 3's GRANT cycle; no commit.
    v[34] = mk(0, 4'h8, 32'h3C121110, 4'h8, 4'h0, 8'h11, 3, 1);
    v[35] = mk(1, 4'h8, 32'h3C121110, 4'h0, 4'h0, 8'h00, 0, 0);
    v[36] = mk(0, 4'h0, 32'h3C121110, 4'h0, 4'h0, 8'h00, 0, 0);
    v[37] = mk(0, 4'h8, 32'h3C121110, 4'h8, 4'h0, 8'h00, 3, 1);
    v[38] = mk(0, 4'h0, 32'h3C121110, 4'h0, 4'h0, 8'h00, 3, 0);

    s_reset = 1'b1; req = '0; wdata = '0;
    for (int i = 0; i < 39; i++) begin
      s_reset = v[i].rst; req = v[i].rq; wdata = v[i].wd;
      @(negedge clk1);
      chk("grant", i, 32'(grant), 32'(v[i].g));
      chk("ack",   i, 32'(ack),   32'(v[i].a));
      chk("q",     i, 32'(q),     32'(v[i].qq));
      chk("owner", i, 32'(owner), 32'(v[i].o));
      chk("busy",  i, 32'(busy),  32'(v[i].b));
      chk("excl",  i, {29'd0, $onehot0(grant), $onehot0(ack), !(|grant && |ack)}, 32'd7);
    end

    // Latency: request at E0, ack visible after E1, bounded wait.
    req = 4'h1; wdata = 32'h0000005A;
    n = 0;
    do begin
      @(negedge clk1);
      n++;
    end while (!ack[0] && n < 10);
    chk("seq_latency", 39, 32'(n), 32'd2);
    chk("seq_q", 39, 32'(q), 32'h5A);
    req = 4'h0;
    @(negedge clk1);
    chk("seq_idle", 40, {30'd0, busy, |ack}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
